// File: rtl/addr_seq_ctrl.sv
// Serial address index sequencer for addr_sel: steps 0..LAST_SERIAL after a start,
// holds on stall, runs a fixed drain window, then emits a one-cycle done pulse.
module addr_seq_ctrl #(
    parameter int ARRAY_SIZE     = 8,
    parameter int QUEUE_SIZE     = 4,
    parameter int QUEUE_COUNT    = (ARRAY_SIZE + 3) / 4,
    parameter int TILE_LEN       = 99,
    parameter int ADDR_WIDTH_MIN = 7,
    parameter int DRAIN_CYCLES   = 2 * ARRAY_SIZE + 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stall,
    input  logic                      abort,
    output logic [ADDR_WIDTH_MIN-1:0] addr_serial_num,
    output logic                      seq_valid,
    output logic                      busy,
    output logic                      draining,
    output logic                      done
);
    localparam int LAST_SERIAL = TILE_LEN - 1 + (QUEUE_COUNT - 1) * QUEUE_SIZE;
    localparam int IDLE_SERIAL = (1 << ADDR_WIDTH_MIN) - 1;
    localparam int DRAIN_W     = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [ADDR_WIDTH_MIN-1:0] LAST_IDX   = ADDR_WIDTH_MIN'(LAST_SERIAL);
    localparam logic [ADDR_WIDTH_MIN-1:0] IDLE_IDX   = ADDR_WIDTH_MIN'(IDLE_SERIAL);
    localparam logic [DRAIN_W-1:0]        DRAIN_LOAD =
        DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    // The idle index must sit outside the live range so every queue reads ADDR_MAX.
    generate
        if (LAST_SERIAL >= IDLE_SERIAL) begin : g_bad_range
            $error("addr_seq_ctrl: LAST_SERIAL must be below IDLE_SERIAL");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                    state_reg, state_next;
    logic [ADDR_WIDTH_MIN-1:0] index_reg, index_next;
    logic [DRAIN_W-1:0]        drain_cnt_reg, drain_cnt_next;
    logic                      seq_valid_reg, seq_valid_next;
    logic                      busy_reg, busy_next;
    logic                      draining_reg, draining_next;
    logic                      done_reg, done_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            index_reg     <= IDLE_IDX;
            drain_cnt_reg <= '0;
            seq_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            draining_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            index_reg     <= index_next;
            drain_cnt_reg <= drain_cnt_next;
            seq_valid_reg <= seq_valid_next;
            busy_reg      <= busy_next;
            draining_reg  <= draining_next;
            done_reg      <= done_next;
        end
    end

    // abort overrides every other input and transition
    always_comb begin
        state_next     = state_reg;
        index_next     = index_reg;
        drain_cnt_next = drain_cnt_reg;
        if (abort) begin
            state_next     = S_IDLE;
            index_next     = IDLE_IDX;
            drain_cnt_next = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_RUN;
                        index_next = '0;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (index_reg == LAST_IDX) begin
                            index_next = IDLE_IDX;
                            if (DRAIN_CYCLES == 0) begin
                                state_next = S_DONE;
                            end else begin
                                state_next     = S_DRAIN;
                                drain_cnt_next = DRAIN_LOAD;
                            end
                        end else begin
                            index_next = index_reg + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_reg == '0) begin
                        state_next = S_DONE;
                    end else begin
                        drain_cnt_next = drain_cnt_reg - 1'b1;
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                    index_next = IDLE_IDX;
                end
            endcase
        end
    end

    // Flags are registered alongside the state they describe; a stall edge in RUN
    // keeps the state but marks the held index as not live.
    always_comb begin
        seq_valid_next = (state_next == S_RUN) && !((state_reg == S_RUN) && stall);
        busy_next      = (state_next != S_IDLE);
        draining_next  = (state_next == S_DRAIN);
        done_next      = (state_next == S_DONE);
    end

    assign addr_serial_num = index_reg;
    assign seq_valid       = seq_valid_reg;
    assign busy            = busy_reg;
    assign draining        = draining_reg;
    assign done            = done_reg;

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Scoreboard bench for addr_seq_ctrl: three instances (default, ARRAY_SIZE=16,
// ARRAY_SIZE=16 with no drain) each with its own expected-event queue.
module tb_addr_seq_ctrl;
    localparam int K        = 10000;
    localparam int EV_IDX   = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_STALL = 2;
    localparam int EV_IDLE  = 3;
    localparam int IDLE_V   = 127;

    logic       clk;
    logic       rst_n;
    logic       start_v    [3];
    logic       stall_v    [3];
    logic       abort_v    [3];
    logic [6:0] addr_v     [3];
    logic       seq_valid_v[3];
    logic       busy_v     [3];
    logic       draining_v [3];
    logic       done_v     [3];

    int exp_q[3][$];
    int checks = 0;
    int errors = 0;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            addr_seq_ctrl #(
                .ARRAY_SIZE  ((gi == 0) ? 8 : 16),
                .DRAIN_CYCLES((gi == 0) ? 18 : ((gi == 1) ? 34 : 0))
            ) u_dut (
                .clk            (clk),
                .rst_n          (rst_n),
                .start          (start_v[gi]),
                .stall          (stall_v[gi]),
                .abort          (abort_v[gi]),
                .addr_serial_num(addr_v[gi]),
                .seq_valid      (seq_valid_v[gi]),
                .busy           (busy_v[gi]),
                .draining       (draining_v[gi]),
                .done           (done_v[gi])
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: turns each observed cycle into an event and checks it against the queue.
    logic busy_prev[3] = '{1'b0, 1'b0, 1'b0};
    logic done_prev[3] = '{1'b0, 1'b0, 1'b0};
    int   drain_n  [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int code;
            int want;
            code = -1;
            if (seq_valid_v[d] === 1'b1) begin
                code = EV_IDX * K + int'(addr_v[d]);
                drain_n[d] = 0;
            end else if (draining_v[d] === 1'b1) begin
                drain_n[d] = drain_n[d] + 1;
                checks = checks + 1;
                if (addr_v[d] !== 7'd127) begin
                    errors = errors + 1;
                    $display("FAIL drain_idx dut%0d got %0d want %0d", d, addr_v[d], IDLE_V);
                end
            end else if (done_v[d] === 1'b1) begin
                code = EV_DONE * K + drain_n[d];
                drain_n[d] = 0;
            end else if (busy_v[d] === 1'b1) begin
                code = EV_STALL * K + int'(addr_v[d]);
            end else if (busy_prev[d] === 1'b1) begin
                code = EV_IDLE * K + int'(addr_v[d]) + ((done_prev[d] === 1'b1) ? 1000 : 0);
            end
            if (code >= 0) begin
                checks = checks + 1;
                if (exp_q[d].size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_event dut%0d got %0d want none", d, code);
                end else begin
                    want = exp_q[d].pop_front();
                    if (want != code) begin
                        errors = errors + 1;
                        $display("FAIL event dut%0d got %0d want %0d", d, code, want);
                    end
                end
            end
            busy_prev[d] = busy_v[d];
            done_prev[d] = done_v[d];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int kind, input int val);
        exp_q[d].push_back(kind * K + val);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic pulse_start(input int d);
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
    endtask

    // Full tile with optional stalls at indices sa/sb and optional ignored start pokes.
    task automatic run_full(input int d, input int last, input int drain,
                            input int sa, input int na, input int sb, input int nb,
                            input bit poke);
        for (int i = 0; i <= last; i++) begin
            push(d, EV_IDX, i);
            if (i == sa) for (int s = 0; s < na; s++) push(d, EV_STALL, i);
            if (i == sb) for (int s = 0; s < nb; s++) push(d, EV_STALL, i);
        end
        push(d, EV_DONE, drain);
        push(d, EV_IDLE, 1000 + IDLE_V);
        $display("run dut%0d last=%0d drain=%0d stall@%0d x%0d stall@%0d x%0d poke=%0d",
                 d, last, drain, sa, na, sb, nb, poke);
        pulse_start(d);
        for (int i = 0; i <= last; i++) begin
            if (i == sa) begin
                stall_v[d] = 1'b1;
                repeat (na) tick();
                stall_v[d] = 1'b0;
            end
            if (i == sb) begin
                stall_v[d] = 1'b1;
                repeat (nb) tick();
                stall_v[d] = 1'b0;
            end
            start_v[d] = poke && (i == 10);
            tick();
            start_v[d] = 1'b0;
        end
        for (int j = 0; j <= drain; j++) begin
            start_v[d] = poke && ((j == 0) || (j == drain));
            tick();
            start_v[d] = 1'b0;
        end
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0;
            stall_v[d] = 1'b0;
            abort_v[d] = 1'b0;
        end
        repeat (2) tick();
        for (int d = 0; d < 3; d++) begin
            chk("reset_addr", int'(addr_v[d]), IDLE_V);
            chk("reset_busy", int'(busy_v[d]), 0);
            chk("reset_valid", int'(seq_valid_v[d]), 0);
            chk("reset_draining", int'(draining_v[d]), 0);
            chk("reset_done", int'(done_v[d]), 0);
        end
        rst_n = 1'b1;
        tick();

        run_full(0, 102, 18, -1, 0, -1, 0, 1'b0);
        run_full(0, 102, 18, 50, 3, 102, 2, 1'b0);

        $display("abort at index 20");
        for (int i = 0; i <= 20; i++) push(0, EV_IDX, i);
        push(0, EV_IDLE, IDLE_V);
        pulse_start(0);
        repeat (20) tick();
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        repeat (3) tick();

        $display("abort during drain");
        for (int i = 0; i <= 102; i++) push(0, EV_IDX, i);
        push(0, EV_IDLE, IDLE_V);
        pulse_start(0);
        repeat (107) tick();
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        repeat (3) tick();

        $display("start with abort in idle");
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk("start_abort_busy", int'(busy_v[0]), 0);
        chk("start_abort_addr", int'(addr_v[0]), IDLE_V);
        repeat (3) tick();

        run_full(0, 102, 18, -1, 0, -1, 0, 1'b1);

        $display("async reset at index 40");
        for (int i = 0; i <= 40; i++) push(0, EV_IDX, i);
        push(0, EV_IDLE, IDLE_V);
        pulse_start(0);
        repeat (40) tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_addr", int'(addr_v[0]), IDLE_V);
        chk("async_reset_busy", int'(busy_v[0]), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_full(0, 102, 18, -1, 0, -1, 0, 1'b0);

        run_full(1, 110, 34, -1, 0, -1, 0, 1'b0);
        run_full(2, 110, 0, -1, 0, -1, 0, 1'b0);

        for (int d = 0; d < 3; d++) chk("queue_empty", exp_q[d].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
